// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between fetch_unit (master) and the instruction RAM (slave).
interface fetch_unit_if;
  logic        imem_write_enable;
  logic [31:0] imem_write_address;
  logic [31:0] imem_data_in;
  logic [31:0] imem_read_address;
  logic [31:0] imem_data_out;

  modport master (
    output imem_write_enable,
    output imem_write_address,
    output imem_data_in,
    output imem_read_address,
    input  imem_data_out
  );

  modport slave (
    input  imem_write_enable,
    input  imem_write_address,
    input  imem_data_in,
    input  imem_read_address,
    output imem_data_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads a program into imem, then fetches into an IF/ID
// register with stall, redirect and halt-opcode handling.
module fetch_unit #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned START_PC    = 0,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic              instr_valid,
  output logic              halted
);

  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN, S_HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   load_ptr, load_ptr_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0]   instr_q, instr_nxt;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_nxt;
  logic                valid_q, valid_nxt;
  logic                ready_q, halted_q;
  logic                write_en;
  logic                unused_target;

  assign unused_target = ^redirect_target[DATA_W-1:ADDR_W];

  // Memory bus: write port is live only while loading, read port always shows pc
  assign imem.imem_write_enable  = write_en;
  assign imem.imem_write_address = DATA_W'(load_ptr);
  assign imem.imem_data_in       = load_data;
  assign imem.imem_read_address  = DATA_W'(pc);

  assign load_ready  = ready_q;
  assign halted      = halted_q;
  assign instr_out   = instr_q;
  assign pc_out      = DATA_W'(pc_out_q);
  assign instr_valid = valid_q;

  // Next-state and datapath; in RUN: redirect > stall > halt detect > issue
  always_comb begin
    state_nxt    = state;
    load_ptr_nxt = load_ptr;
    pc_nxt       = pc;
    instr_nxt    = instr_q;
    pc_out_nxt   = pc_out_q;
    valid_nxt    = valid_q;
    write_en     = 1'b0;
    case (state)
      S_LOAD: begin
        write_en  = load_valid;
        valid_nxt = 1'b0;
        if (load_valid) begin
          load_ptr_nxt = load_ptr + ONE;
          if (load_last || (load_ptr == PTR_MAX)) state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = PC_INIT;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target[ADDR_W-1:0];
          valid_nxt = 1'b0;
        end else if (stall) begin
          valid_nxt = valid_q;
        end else if (imem.imem_data_out[31:26] == HALT_OPCODE) begin
          valid_nxt = 1'b0;
          state_nxt = S_HALT;
        end else begin
          instr_nxt  = imem.imem_data_out;
          pc_out_nxt = pc;
          valid_nxt  = 1'b1;
          pc_nxt     = pc + ONE;
        end
      end
      S_HALT: begin
        valid_nxt = 1'b0;
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = PC_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      load_ptr <= '0;
      pc       <= PC_INIT;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      load_ptr <= load_ptr_nxt;
      pc       <= pc_nxt;
      instr_q  <= instr_nxt;
      pc_out_q <= pc_out_nxt;
      valid_q  <= valid_nxt;
      ready_q  <= (state_nxt == S_LOAD);
      halted_q <= (state_nxt == S_HALT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural program/fetch model checked every cycle,
// plus directed load/run/stall/redirect/halt/full-load/reset scenarios.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] W0 = 32'h2008_0020;  // addi r8,r0,0x20
  localparam logic [31:0] W1 = 32'h2009_0001;  // addi r9,r0,1
  localparam logic [31:0] W2 = 32'hAD09_0000;  // sw r9,0(r8)
  localparam logic [31:0] W3 = 32'h8D0A_0000;  // lw r10,0(r8)
  localparam logic [31:0] WH = 32'hFC00_0000;  // halt

  logic        clk = 1'b0;
  logic        rst_n, load_valid, load_last, start, stall, redirect_valid;
  logic        load_ready, instr_valid, halted;
  logic [31:0] load_data, redirect_target, instr_out, pc_out;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.ADDR_W(10), .START_PC(0), .HALT_OPCODE(6'h3F)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem(bus), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .halted(halted)
  );

  // Instruction RAM: synchronous write, combinational read
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  always @(posedge clk)
    if (bus.imem_write_enable) mem[bus.imem_write_address[9:0]] <= bus.imem_data_in;
  assign bus.imem_data_out = mem[bus.imem_read_address[9:0]];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program image, load pointer, pc and issued instruction as plain integers
  int          m_mode;   // 0 load, 1 idle, 2 run, 3 halt
  int unsigned m_ptr, m_pc, m_pco;
  logic [31:0] m_instr;
  bit          m_valid;
  logic [31:0] img [DEPTH] = '{default: 32'h0};

  initial begin
    bit live;
    logic [31:0] word;
    live = 1'b0;
    forever begin
      @(negedge clk);
      if (live) begin
        check("load_ready",  32'(load_ready), 32'(m_mode == 0));
        check("write_en",    32'(bus.imem_write_enable), 32'(m_mode == 0 && load_valid));
        if (m_mode == 0 && load_valid) begin
          check("write_addr", bus.imem_write_address, 32'(m_ptr));
          check("write_data", bus.imem_data_in, load_data);
        end
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted",      32'(halted), 32'(m_mode == 3));
        check("instr_out",   instr_out, m_instr);
        check("pc_out",      pc_out, 32'(m_pco));
        if (m_mode >= 2) check("read_addr", bus.imem_read_address, 32'(m_pc));
      end
      // Predict the state after the coming rising edge
      if (!rst_n) begin
        m_mode = 0; m_ptr = 0; m_pc = 0; m_pco = 0; m_instr = '0; m_valid = 1'b0;
      end else begin
        case (m_mode)
          0: begin
            m_valid = 1'b0;
            if (load_valid) begin
              img[m_ptr] = load_data;
              if (load_last || m_ptr == DEPTH - 1) m_mode = 1;
              m_ptr = (m_ptr + 1) % DEPTH;
            end
          end
          2: begin
            word = img[m_pc];
            if (redirect_valid) begin
              m_pc = redirect_target % DEPTH;
              m_valid = 1'b0;
            end else if (stall) begin
              m_valid = m_valid;
            end else if (word[31:26] == 6'h3F) begin
              m_valid = 1'b0;
              m_mode = 3;
            end else begin
              m_instr = word; m_pco = m_pc; m_valid = 1'b1;
              m_pc = (m_pc + 1) % DEPTH;
            end
          end
          default: begin
            m_valid = 1'b0;
            if (start) begin m_mode = 2; m_pc = 0; end
          end
        endcase
      end
      live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last, input int addr);
    load_valid = 1'b1; load_data = d; load_last = last;
    #1;
    check("lit_write_addr", bus.imem_write_address, 32'(addr));
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("lit_reset_ready", 32'(load_ready), 32'd1);
    check("lit_reset_valid", 32'(instr_valid), 32'd0);
    check("lit_reset_pc_out", pc_out, 32'd0);

    // Load four words and run them
    load_word(W0, 1'b0, 0); load_word(W1, 1'b0, 1);
    load_word(W2, 1'b0, 2); load_word(W3, 1'b1, 3);
    check("lit_idle_ready", 32'(load_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("lit_run_valid0", 32'(instr_valid), 32'd0);
    tick();
    check("lit_pc_out0", pc_out, 32'd0); check("lit_instr0", instr_out, W0);
    tick();
    check("lit_pc_out1", pc_out, 32'd1); check("lit_instr1", instr_out, W1);

    // Two-cycle stall holds IF/ID
    stall = 1'b1; tick();
    check("lit_stall_a", pc_out, 32'd1);
    tick();
    check("lit_stall_b", pc_out, 32'd1); check("lit_stall_v", 32'(instr_valid), 32'd1);
    stall = 1'b0; tick();
    check("lit_after_stall", pc_out, 32'd2); check("lit_instr2", instr_out, W2);

    // Redirect to 0, then to 3 while pc is 1
    redirect_valid = 1'b1; redirect_target = 32'd0; tick(); redirect_valid = 1'b0;
    check("lit_redir_flush", 32'(instr_valid), 32'd0);
    tick();
    check("lit_redir0_pc", pc_out, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'd3; tick(); redirect_valid = 1'b0;
    check("lit_redir3_addr", bus.imem_read_address, 32'd3);
    tick();
    check("lit_redir3_pc", pc_out, 32'd3); check("lit_instr3", instr_out, W3);

    // Redirect beats stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd1; tick(); redirect_valid = 1'b0;
    check("lit_redir_stall_addr", bus.imem_read_address, 32'd1);
    tick(); stall = 1'b0; tick();
    check("lit_redir_stall_pc", pc_out, 32'd1);
    repeat (3) tick();
    check("lit_pc5", bus.imem_read_address, 32'd5);

    // Reset mid-run, then load a program that halts at address 2
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("lit_rst_valid", 32'(instr_valid), 32'd0);
    check("lit_rst_halted", 32'(halted), 32'd0);
    check("lit_rst_ready", 32'(load_ready), 32'd1);
    load_word(W0, 1'b0, 0); load_word(W1, 1'b0, 1); load_word(WH, 1'b1, 2);
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    check("lit_pre_halt_pc", pc_out, 32'd1);
    tick();
    check("lit_halted", 32'(halted), 32'd1);
    check("lit_halt_addr", bus.imem_read_address, 32'd2);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd0; tick();
    stall = 1'b0; redirect_valid = 1'b0;
    check("lit_halt_ignores_redir", bus.imem_read_address, 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    check("lit_restart_halted", 32'(halted), 32'd0);
    check("lit_restart_addr", bus.imem_read_address, 32'd0);
    repeat (3) tick();

    // Full-memory load without load_last
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    load_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_data = 32'h1000_0000 + 32'(i);
      if (i == int'(DEPTH) - 1) begin
        #1 check("lit_last_write_addr", bus.imem_write_address, 32'd1023);
      end
      tick();
    end
    check("lit_full_ready", 32'(load_ready), 32'd0);
    check("lit_full_no_write", 32'(bus.imem_write_enable), 32'd0);
    tick();
    load_valid = 1'b0;
    check("lit_mem0_kept", mem[0], 32'h1000_0000);
    check("lit_mem1023", mem[1023], 32'h1000_03FF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("lit_full_instr0", instr_out, 32'h1000_0000);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address to the instruction memory.
- Captures the returned word into an IF/ID output register for decode, and supports stall and branch/jump redirect.
- Also acts as the program loader: it streams host words into the instruction memory through its write port before execution starts.

Parameters:
ADDR_W, 10, PC/address width in words (1024-word instruction memory)
START_PC, 0, PC value on entry to RUN
HALT_OPCODE, 6'h3F, opcode (bits 31:26) that stops fetch

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
load_valid  input  1  host offers a program word
load_data  input  32  program word
load_last  input  1  marks final program word
load_ready  output  1  fetch_unit accepts load word this cycle
start  input  1  begin/restart execution
stall  input  1  downstream hazard; hold PC and IF/ID
redirect_valid  input  1  taken branch/jump from later stage
redirect_target  input  32  new word address (low ADDR_W bits used)
imem_write_enable  output  1  instruction memory write strobe
imem_write_address  output  32  write word address, zero-extended
imem_data_in  output  32  write data
imem_read_address  output  32  PC, zero-extended
imem_data_out  input  32  instruction word, combinational from imem_read_address
instr_out  output  32  IF/ID instruction
pc_out  output  32  IF/ID PC of instr_out, zero-extended
instr_valid  output  1  instr_out/pc_out hold a real instruction
halted  output  1  high in HALT state

Behaviour:
- Reset (rst_n low at an edge, any state, mid-load or mid-run):
  - state=LOAD, load_ptr=0, pc=START_PC.
  - instr_out=0, pc_out=0, instr_valid=0, halted=0.
- Word addressing: pc and load_ptr are ADDR_W bits and increment by 1. They wrap from 2^ADDR_W-1 to 0.
- States: LOAD, IDLE, RUN, HALT.
- LOAD:
  - load_ready=1. imem_write_enable=load_valid, imem_write_address=load_ptr, imem_data_in=load_data, all combinational.
  - On accept (load_valid&load_ready): load_ptr++.
  - Go to IDLE if load_last is set, or if load_ptr was 2^ADDR_W-1 (memory full; no wrap-overwrite).
  - start is ignored in LOAD.
- In every state other than LOAD: load_ready=0 and imem_write_enable=0.
- IDLE:
  - instr_valid=0.
  - start -> RUN, pc=START_PC.
- RUN: imem_read_address=pc every cycle. Per-cycle priority:
  1. redirect_valid: pc<=redirect_target[ADDR_W-1:0]; instr_valid<=0 (flush); instr_out/pc_out hold. Wins over stall and over halt detection.
  2. stall: pc, instr_out, pc_out, instr_valid all hold.
  3. Fetched opcode (imem_data_out[31:26]) equals HALT_OPCODE: halt word not issued; instr_valid<=0; pc holds at halt address; go to HALT.
  4. Otherwise: instr_out<=imem_data_out, pc_out<=pc, instr_valid<=1, pc<=pc+1.
- Fetch latency: instruction at address A appears on instr_out one edge after pc==A with no stall and no redirect.
- HALT:
  - halted=1, instr_valid=0, pc frozen.
  - start -> RUN at START_PC; halted=0 from the next cycle.
  - redirect and stall are ignored in HALT.
- A stalled halt word is not detected until stall drops.
- load_data is never checked for HALT_OPCODE.

Test Plan:
- Load + run: load 4 words (addi r8,r0,0x20; addi r9,r0,1; sw; lw), load_last on word 3 -> imem writes at addresses 0..3, state IDLE. Pulse start -> instr_valid rises next edge with pc_out 0,1,2,3 and the matching words, one per cycle.
- Stall: assert stall 2 cycles while pc_out=1 -> instr_out/pc_out/instr_valid frozen for both cycles. pc_out=2 appears on the first edge after stall drops.
- Redirect: redirect_valid with target 0x3 while pc=1 -> next cycle instr_valid=0, imem_read_address=3. Following edge pc_out=3. Repeat with stall and redirect together -> redirect wins.
- Halt: word 0xFC000000 at address 2 -> pc_out 0,1 issued, then instr_valid=0, halted=1, pc frozen at 2. start -> restart at pc 0.
- Full-memory load: 1024 words without load_last -> the 1024th write goes to address 1023, then IDLE and load_ready=0. A further load_valid causes no write.
- Reset mid-run: drop rst_n for 1 cycle at pc=5 -> instr_valid=0, halted=0, LOAD state, load_ptr=0. A new load starts writing at address 0.
